// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core's nibble-serial datapath and UART.
// The TX and RX sides both take their default bit period from UART_CLKS_PER_BIT.
package idli_pkg;

   typedef logic [3:0] sqi_data_t;
   typedef logic [7:0] uart_byte_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_rx_state_t;

   localparam int UART_CLKS_PER_BIT = 16;

endpackage

// File: rtl/idli_uart_rx_fifo_m.sv
// Receive byte FIFO for the UART RX: power-of-two depth, wrap-bit pointers.
// The caller only pushes when there is room (or a pop frees it) and only pops when non-empty.
module idli_uart_rx_fifo_m
   import idli_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       gck,
   input  logic       rst,
   input  logic       push,
   input  uart_byte_t push_data,
   input  logic       pop,
   output uart_byte_t head,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   uart_byte_t    mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;

   always_ff @(posedge gck or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: empty masks the head until a byte has been written.
   always_ff @(posedge gck) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/idli_uart_rx_m.sv
// UART 8N1 receiver: synchronizes the line, decodes frames LSB first, queues bytes
// and hands each one out as low nibble then high nibble under valid/accept.
module idli_uart_rx_m
   import idli_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic      i_urx_gck,
   input  logic      i_urx_rst,
   input  logic      i_urx_rx,
   output sqi_data_t o_urx_data,
   output logic      o_urx_vld,
   input  logic      i_urx_acp,
   output logic      o_urx_ferr,
   output logic      o_urx_ovf
);

   localparam int            CW          = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT/2 - 1);
   localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);

   logic           rx_meta;
   logic           rx_s;
   uart_rx_state_t state;
   uart_rx_state_t state_nxt;
   logic [CW-1:0]  sample_cnt;
   logic [CW-1:0]  sample_cnt_nxt;
   logic [2:0]     bit_cnt;
   logic [2:0]     bit_cnt_nxt;
   uart_byte_t     shift;
   uart_byte_t     shift_nxt;
   logic           cnt_zero;
   logic           push;
   logic           pop;
   logic           full;
   logic           empty;
   logic           ferr_nxt;
   logic           ovf_nxt;
   logic           nib_sel;
   uart_byte_t     head;

   // Two-flop synchronizer; resets to the idle line level so reset cannot fake a start bit.
   always_ff @(posedge i_urx_gck or posedge i_urx_rst) begin
      if (i_urx_rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_urx_rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge i_urx_gck or posedge i_urx_rst) begin
      if (i_urx_rst) begin
         state      <= IDLE;
         sample_cnt <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         o_urx_ferr <= 1'b0;
         o_urx_ovf  <= 1'b0;
      end else begin
         state      <= state_nxt;
         sample_cnt <= sample_cnt_nxt;
         bit_cnt    <= bit_cnt_nxt;
         shift      <= shift_nxt;
         o_urx_ferr <= ferr_nxt;
         o_urx_ovf  <= ovf_nxt;
      end
   end

   assign cnt_zero = (sample_cnt == '0);

   always_comb begin
      state_nxt      = state;
      sample_cnt_nxt = cnt_zero ? sample_cnt : sample_cnt - CW'(1);
      bit_cnt_nxt    = bit_cnt;
      shift_nxt      = shift;
      push           = 1'b0;
      ferr_nxt       = 1'b0;
      ovf_nxt        = o_urx_ovf;
      unique case (state)
         IDLE: begin
            if (!rx_s) begin
               state_nxt      = START;
               sample_cnt_nxt = HALF_RELOAD;
            end
         end
         START: begin
            if (cnt_zero) begin
               state_nxt      = rx_s ? IDLE : DATA;
               sample_cnt_nxt = FULL_RELOAD;
            end
         end
         DATA: begin
            if (cnt_zero) begin
               shift_nxt      = {rx_s, shift[7:1]};
               bit_cnt_nxt    = bit_cnt + 3'd1;
               sample_cnt_nxt = FULL_RELOAD;
               if (bit_cnt == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            // A pop in the same cycle frees the head entry, so the push still fits.
            if (cnt_zero) begin
               if (rx_s) begin
                  state_nxt = IDLE;
                  if (!full || pop) push    = 1'b1;
                  else              ovf_nxt = 1'b1;
               end else begin
                  state_nxt = BREAK;
                  ferr_nxt  = 1'b1;
               end
            end
         end
         BREAK: begin
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Low nibble goes out first; the byte leaves the FIFO once its high nibble is taken.
   always_ff @(posedge i_urx_gck or posedge i_urx_rst) begin
      if (i_urx_rst)                   nib_sel <= 1'b0;
      else if (o_urx_vld && i_urx_acp) nib_sel <= ~nib_sel;
   end

   assign pop        = o_urx_vld && i_urx_acp && nib_sel;
   assign o_urx_vld  = !empty;
   assign o_urx_data = !o_urx_vld ? '0 : (nib_sel ? head[7:4] : head[3:0]);

   idli_uart_rx_fifo_m #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .gck      (i_urx_gck),
      .rst      (i_urx_rst),
      .push     (push),
      .push_data(shift),
      .pop      (pop),
      .head     (head),
      .full     (full),
      .empty    (empty)
   );

endmodule

// File: tb/tb_idli_uart_rx_m.sv
// Directed bench for idli_uart_rx_m: bit-timed 8N1 line stimulus, nibbles captured
// on the falling clock edge and compared against hand-computed sequences.
module tb_idli_uart_rx_m;
   import idli_pkg::*;

   localparam int CPB = 16;

   logic      clk = 1'b0;
   logic      rst = 1'b1;
   logic      rx  = 1'b1;
   logic      acp = 1'b0;
   sqi_data_t data;
   logic      vld;
   logic      ferr;
   logic      ovf;

   int checks   = 0;
   int errors   = 0;
   int cycle    = 0;
   int ferr_cnt = 0;
   int vld_cnt  = 0;
   sqi_data_t got[$];
   int        got_cyc[$];

   idli_uart_rx_m #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (4)
   ) dut (
      .i_urx_gck (clk),
      .i_urx_rst (rst),
      .i_urx_rx  (rx),
      .o_urx_data(data),
      .o_urx_vld (vld),
      .i_urx_acp (acp),
      .o_urx_ferr(ferr),
      .o_urx_ovf (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Record every accepted nibble and count ferr pulses / valid cycles.
   always @(negedge clk) begin
      if (!rst) begin
         if (vld) vld_cnt++;
         if (ferr) ferr_cnt++;
         if (vld && acp) begin
            got.push_back(data);
            got_cyc.push_back(cycle);
         end
      end
   end

   task automatic clear_capture();
      got.delete();
      got_cyc.delete();
      ferr_cnt = 0;
      vld_cnt  = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx  = 1'b1;
      acp = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      clear_capture();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic bit_time(input logic v);
      rx = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
      bit_time(stop_bit);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld got %b want 0", vld); end
      checks++;
      if (data !== 4'h0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", data); end
      checks++;
      if (ferr !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr got %b want 0", ferr); end
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
   endtask

   task automatic test_basic_byte();
      sqi_data_t exp_q[$];
      sqi_data_t obs;
      int        gap;
      exp_q = '{4'h5, 4'hA};
      do_reset();
      acp = 1'b1;
      send_frame(8'hA5, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (got.size() != exp_q.size()) begin errors++; $display("[TB] FAIL basic_count got %0d want %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = (i < got.size()) ? got[i] : 4'hx;
         checks++;
         if (obs !== exp_q[i]) begin errors++; $display("[TB] FAIL basic_nibble%0d got %h want %h", i, obs, exp_q[i]); end
      end
      gap = (got_cyc.size() >= 2) ? got_cyc[1] - got_cyc[0] : -1;
      checks++;
      if (gap != 1) begin errors++; $display("[TB] FAIL basic_consecutive got gap %0d want 1", gap); end
      checks++;
      if (ferr_cnt != 0) begin errors++; $display("[TB] FAIL basic_ferr got %0d pulses want 0", ferr_cnt); end
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf got %b want 0", ovf); end
   endtask

   task automatic test_glitch();
      do_reset();
      acp = 1'b1;
      rx  = 1'b0;
      repeat (6) @(posedge clk);
      #1 rx = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL glitch_state got %0d want %0d", dut.state, IDLE); end
      checks++;
      if (vld_cnt != 0) begin errors++; $display("[TB] FAIL glitch_vld got %0d cycles want 0", vld_cnt); end
      checks++;
      if (ferr_cnt != 0) begin errors++; $display("[TB] FAIL glitch_ferr got %0d pulses want 0", ferr_cnt); end
   endtask

   task automatic test_framing_error();
      sqi_data_t exp_q[$];
      sqi_data_t obs;
      exp_q = '{4'h1, 4'h8};
      do_reset();
      acp = 1'b1;
      send_frame(8'h3C, 1'b0);
      rx = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (ferr_cnt != 1) begin errors++; $display("[TB] FAIL ferr_pulses got %0d want 1", ferr_cnt); end
      checks++;
      if (vld_cnt != 0) begin errors++; $display("[TB] FAIL ferr_vld got %0d cycles want 0", vld_cnt); end
      checks++;
      if (dut.state !== BREAK) begin errors++; $display("[TB] FAIL ferr_break_state got %0d want %0d", dut.state, BREAK); end
      rx = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      send_frame(8'h81, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (got.size() != exp_q.size()) begin errors++; $display("[TB] FAIL ferr_next_count got %0d want %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = (i < got.size()) ? got[i] : 4'hx;
         checks++;
         if (obs !== exp_q[i]) begin errors++; $display("[TB] FAIL ferr_next_nibble%0d got %h want %h", i, obs, exp_q[i]); end
      end
      checks++;
      if (ferr_cnt != 1) begin errors++; $display("[TB] FAIL ferr_next_pulses got %0d want 1", ferr_cnt); end
   endtask

   task automatic test_overflow();
      sqi_data_t  exp_q[$];
      sqi_data_t  obs;
      uart_byte_t bytes[5];
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      exp_q = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};
      do_reset();
      for (int i = 0; i < 5; i++) send_frame(bytes[i], 1'b1);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b want 1", ovf); end
      checks++;
      if (vld !== 1'b1 || data !== 4'h1) begin errors++; $display("[TB] FAIL ovf_stall_head got vld=%b data=%h want vld=1 data=1", vld, data); end
      acp = 1'b1;
      repeat (12) @(posedge clk);
      #1 acp = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (got.size() != exp_q.size()) begin errors++; $display("[TB] FAIL ovf_drain_count got %0d want %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = (i < got.size()) ? got[i] : 4'hx;
         checks++;
         if (obs !== exp_q[i]) begin errors++; $display("[TB] FAIL ovf_drain_nibble%0d got %h want %h", i, obs, exp_q[i]); end
      end
      checks++;
      if (vld !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drained_vld got %b want 0", vld); end
      checks++;
      if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b want 1", ovf); end
   endtask

   task automatic test_push_pop_full();
      sqi_data_t  exp_q[$];
      sqi_data_t  obs;
      uart_byte_t bytes[4];
      bit         found;
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      exp_q = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4, 4'h5, 4'h5};
      found = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) send_frame(bytes[i], 1'b1);
      // Take the low nibble now so the next accept pops the head.
      acp = 1'b1;
      @(posedge clk);
      #1 acp = 1'b0;
      fork
         send_frame(8'h55, 1'b1);
         begin
            for (int i = 0; i < 400; i++) begin
               @(negedge clk);
               if (dut.state == STOP && dut.sample_cnt == 1) begin
                  found = 1'b1;
                  break;
               end
            end
            if (found) begin
               @(posedge clk);
               #1 acp = 1'b1;
               @(posedge clk);
               #1 acp = 1'b0;
            end
         end
      join
      checks++;
      if (!found) begin errors++; $display("[TB] FAIL pushpop_timeout got no stop sample within 400 cycles want one"); end
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_ovf got %b want 0", ovf); end
      acp = 1'b1;
      repeat (14) @(posedge clk);
      #1 acp = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (got.size() != exp_q.size()) begin errors++; $display("[TB] FAIL pushpop_count got %0d want %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = (i < got.size()) ? got[i] : 4'hx;
         checks++;
         if (obs !== exp_q[i]) begin errors++; $display("[TB] FAIL pushpop_nibble%0d got %h want %h", i, obs, exp_q[i]); end
      end
      checks++;
      if (vld !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_drained_vld got %b want 0", vld); end
   endtask

   task automatic test_reset_mid_frame();
      sqi_data_t exp_q[$];
      sqi_data_t obs;
      exp_q = '{4'hF, 4'h0};
      do_reset();
      send_frame(8'h12, 1'b1);
      send_frame(8'h34, 1'b1);
      repeat (10) @(posedge clk);
      #1 acp = 1'b1;
      @(posedge clk);
      #1 acp = 1'b0;
      checks++;
      if (vld !== 1'b1 || data !== 4'h1) begin errors++; $display("[TB] FAIL rstmid_pre got vld=%b data=%h want vld=1 data=1", vld, data); end
      fork
         send_frame(8'h7E, 1'b1);
         begin
            repeat (60) @(posedge clk);
            #2;
            checks++;
            if (dut.state !== DATA) begin errors++; $display("[TB] FAIL rstmid_state got %0d want %0d", dut.state, DATA); end
            rst = 1'b1;
            #1;
            checks++;
            if (vld !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_vld got %b want 0", vld); end
            checks++;
            if (data !== 4'h0) begin errors++; $display("[TB] FAIL rstmid_data got %h want 0", data); end
            checks++;
            if (ferr !== 1'b0 || ovf !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_flags got ferr=%b ovf=%b want 0 0", ferr, ovf); end
         end
      join
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      clear_capture();
      repeat (4) @(posedge clk);
      #1 acp = 1'b1;
      send_frame(8'h0F, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (got.size() != exp_q.size()) begin errors++; $display("[TB] FAIL rstmid_after_count got %0d want %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = (i < got.size()) ? got[i] : 4'hx;
         checks++;
         if (obs !== exp_q[i]) begin errors++; $display("[TB] FAIL rstmid_after_nibble%0d got %h want %h", i, obs, exp_q[i]); end
      end
      checks++;
      if (ferr_cnt != 0) begin errors++; $display("[TB] FAIL rstmid_after_ferr got %0d pulses want 0", ferr_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic_byte();
      test_glitch();
      test_framing_error();
      test_overflow();
      test_push_pop_full();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
